// File: rtl/mp_mem_arbiter_n.sv
// rtl/mp_mem_arbiter_n.sv - N-core burst arbiter in front of one single-port memory
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req/we                 per-core request (held for the whole burst) and write enable
//   addr/wdata/burst_len   per-core fields, flattened; core i at [i*W +: W]
//   gnt                    registered one-hot grant
//   rvalid/rdata/rcore_id  read return, one cycle after each read beat
//   burst_id               8-bit tag of the current or most recent burst
//
// Build option: define MP_ARB_FIXED_PRIO_EN to select lowest-index-wins
// arbitration instead of round-robin.

module mp_mem_arbiter_n #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int BLW       = 2,
  parameter int CIW       = $clog2(NUM_CORES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CORES-1:0]     req,
  input  logic [NUM_CORES-1:0]     we,
  input  logic [NUM_CORES*AW-1:0]  addr,
  input  logic [NUM_CORES*DW-1:0]  wdata,
  input  logic [NUM_CORES*BLW-1:0] burst_len,
  output logic [NUM_CORES-1:0]     gnt,
  output logic                     rvalid,
  output logic [DW-1:0]            rdata,
  output logic [CIW-1:0]           rcore_id,
  output logic [7:0]               burst_id
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] gnt_d;
  logic [CIW-1:0]       owner_q, owner_d;
  logic [BLW-1:0]       k_q, k_d;
  logic [AW-1:0]        base_q, base_d;
  logic                 dir_q, dir_d;
  logic [BLW-1:0]       len_q, len_d;
  logic [7:0]           burst_id_d;
  logic [CIW-1:0]       start;
  logic [CIW-1:0]       win;
  logic [CIW-1:0]       owner_next;

  logic [AW-1:0]        core_addr;
  logic [DW-1:0]        core_wdata;
  logic [BLW-1:0]       core_len;
  logic                 core_we;

  logic                 beat;
  logic                 first;
  logic                 last;
  logic [AW-1:0]        acc_addr;
  logic                 acc_we;
  logic                 wr_en;
  logic                 rd_en;

  logic [DW-1:0]        mem [0:(1<<AW)-1];

`ifdef MP_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [CIW-1:0]       rr_ptr_q, rr_ptr_d;
  assign start = rr_ptr_q;
`endif

  // First requester at or above start; falls back to the lowest requester
  // when none exists above it, which is the upward search with wrap.
  function automatic logic [CIW-1:0] pick(input logic [NUM_CORES-1:0] r,
                                          input logic [CIW-1:0] from);
    logic [CIW-1:0] lo;
    logic [CIW-1:0] hi;
    logic           hi_found;
    lo       = '0;
    hi       = '0;
    hi_found = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r[i]) begin
        lo = CIW'(i);
        if (CIW'(i) >= from) begin
          hi       = CIW'(i);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? hi : lo;
  endfunction

  assign win        = pick(req, start);
  assign owner_next = (owner_q == CIW'(NUM_CORES - 1)) ? '0 : owner_q + CIW'(1);

  // Fields of the core currently owning the grant.
  always_comb begin
    core_addr  = '0;
    core_wdata = '0;
    core_len   = '0;
    core_we    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (owner_q == CIW'(i)) begin
        core_addr  = addr[i*AW +: AW];
        core_wdata = wdata[i*DW +: DW];
        core_len   = burst_len[i*BLW +: BLW];
        core_we    = we[i];
      end
    end
  end

  // gnt is only non-zero in BURST, so this is also the in-burst qualifier.
  assign beat     = |(req & gnt);
  assign first    = (k_q == '0);
  assign last     = (k_q == (first ? core_len : len_q));
  assign acc_addr = first ? core_addr : base_q + AW'(k_q);
  assign acc_we   = first ? core_we : dir_q;
  assign wr_en    = beat && acc_we;
  assign rd_en    = beat && !acc_we;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt;
    owner_d    = owner_q;
    k_d        = k_q;
    base_d     = base_q;
    dir_d      = dir_q;
    len_d      = len_q;
    burst_id_d = burst_id;
`ifndef MP_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d      = NUM_CORES'(1) << win;
          owner_d    = win;
          burst_id_d = burst_id + 8'd1;
          k_d        = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (!beat || last) begin
          // Abort (owner dropped req) and normal completion both release.
          gnt_d   = '0;
          state_d = IDLE;
`ifndef MP_ARB_FIXED_PRIO_EN
          rr_ptr_d = owner_next;
`endif
        end else begin
          k_d = k_q + BLW'(1);
        end
        if (beat && first) begin
          base_d = core_addr;
          dir_d  = core_we;
          len_d  = core_len;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt      <= '0;
      owner_q  <= '0;
      k_q      <= '0;
      base_q   <= '0;
      dir_q    <= 1'b0;
      len_q    <= '0;
      burst_id <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rcore_id <= '0;
`ifndef MP_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      owner_q  <= owner_d;
      k_q      <= k_d;
      base_q   <= base_d;
      dir_q    <= dir_d;
      len_q    <= len_d;
      burst_id <= burst_id_d;
      rvalid   <= rd_en;
      if (rd_en) begin
        rdata    <= mem[acc_addr];
        rcore_id <= owner_q;
      end
`ifndef MP_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Memory is not reset; writes are suppressed while rst is asserted.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[acc_addr] <= core_wdata;
    end
  end

endmodule

// File: tb/tb_mp_mem_arbiter_n.sv
// tb/tb_mp_mem_arbiter_n.sv - directed self-checking bench for mp_mem_arbiter_n

module tb_mp_mem_arbiter_n;

  localparam int NC  = 4;
  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int BLW = 2;
  localparam int CIW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req_v;
  logic [NC-1:0]     we_v;
  logic [NC*AW-1:0]  addr_v;
  logic [NC*DW-1:0]  wdata_v;
  logic [NC*BLW-1:0] len_v;
  logic [NC-1:0]     gnt;
  logic              rvalid;
  logic [DW-1:0]     rdata;
  logic [CIW-1:0]    rcore_id;
  logic [7:0]        burst_id;

  int passed = 0;
  int total  = 0;

  mp_mem_arbiter_n #(.NUM_CORES(NC), .AW(AW), .DW(DW), .BLW(BLW), .CIW(CIW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req_v),
    .we        (we_v),
    .addr      (addr_v),
    .wdata     (wdata_v),
    .burst_len (len_v),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rcore_id  (rcore_id),
    .burst_id  (burst_id)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BLW-1:0] l);
    req_v[c]               = r;
    we_v[c]                = w;
    addr_v[c*AW +: AW]     = a;
    wdata_v[c*DW +: DW]    = d;
    len_v[c*BLW +: BLW]    = l;
  endtask

  int rr_exp [6];

  initial begin
`ifdef MP_ARB_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 3, 0, 1, 3};
`endif
    rst     = 1'b1;
    req_v   = '1;
    we_v    = '0;
    addr_v  = '0;
    wdata_v = '0;
    len_v   = '0;

    // Reset hold with every core requesting
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_bid", 32'(burst_id), 0);
    end
    rst   = 1'b0;
    req_v = '0;
    cyc();
    check("idle_gnt", 32'(gnt), 0);

    // Core 2 single write then read
    set_core(2, 1'b1, 1'b1, 11'h010, 8'hA5, 2'd0);
    cyc();
    check("w1_gnt", 32'(gnt), 32'h4);
    check("w1_bid", 32'(burst_id), 1);
    cyc();
    check("w1_rel", 32'(gnt), 0);
    check("w1_norv", 32'(rvalid), 0);
    set_core(2, 1'b1, 1'b0, 11'h010, 8'h00, 2'd0);
    cyc();
    check("r1_gnt", 32'(gnt), 32'h4);
    check("r1_bid", 32'(burst_id), 2);
    check("r1_lat", 32'(rvalid), 0);
    cyc();
    check("r1_rvalid", 32'(rvalid), 1);
    check("r1_rdata", 32'(rdata), 32'hA5);
    check("r1_rcore", 32'(rcore_id), 2);
    check("r1_rel", 32'(gnt), 0);
    set_core(2, 1'b0, 1'b0, 11'h0, 8'h0, 2'd0);
    cyc();
    check("r1_pulse", 32'(rvalid), 0);

    // Reset pulse restores rr_ptr and burst_id
    rst = 1'b1;
    cyc();
    check("rst2_bid", 32'(burst_id), 0);
    rst = 1'b0;

    // Round-robin among cores 0,1,3
    set_core(0, 1'b1, 1'b0, 11'h010, 8'h0, 2'd0);
    set_core(1, 1'b1, 1'b0, 11'h010, 8'h0, 2'd0);
    set_core(3, 1'b1, 1'b0, 11'h010, 8'h0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(1) << rr_exp[i]);
      cyc();
      check($sformatf("rr_gap%0d", i), 32'(gnt), 0);
      check($sformatf("rr_rv%0d", i), 32'(rvalid), 1);
      check($sformatf("rr_core%0d", i), 32'(rcore_id), 32'(rr_exp[i]));
      check($sformatf("rr_data%0d", i), 32'(rdata), 32'hA5);
    end
    req_v = '0;

    // Core 1 4-beat write wrapping past the top of memory; later-beat
    // addr/we/len are scrambled and must be ignored.
    set_core(1, 1'b1, 1'b1, 11'h7FE, 8'd1, 2'd3);
    cyc();
    check("bw_bid", 32'(burst_id), 7);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("bw_gnt%0d", b), 32'(gnt), 32'h2);
      if (b > 0) set_core(1, 1'b1, 1'b0, 11'h123, 8'(b + 1), 2'd0);
      cyc();
    end
    check("bw_rel", 32'(gnt), 0);

    // 4-beat read back of the wrapped burst
    set_core(1, 1'b1, 1'b0, 11'h7FE, 8'h0, 2'd3);
    cyc();
    check("br_gnt", 32'(gnt), 32'h2);
    check("br_bid", 32'(burst_id), 8);
    for (int b = 0; b < 4; b++) begin
      cyc();
      check($sformatf("br_rv%0d", b), 32'(rvalid), 1);
      check($sformatf("br_data%0d", b), 32'(rdata), 32'(b + 1));
      check($sformatf("br_core%0d", b), 32'(rcore_id), 1);
    end
    check("br_rel", 32'(gnt), 0);
    set_core(1, 1'b0, 1'b0, 11'h0, 8'h0, 2'd0);

    // Address 0x000 holds the third wrapped beat
    set_core(3, 1'b1, 1'b0, 11'h000, 8'h0, 2'd0);
    cyc();
    check("w0_gnt", 32'(gnt), 32'h8);
    check("w0_bid", 32'(burst_id), 9);
    cyc();
    check("w0_rv", 32'(rvalid), 1);
    check("w0_data", 32'(rdata), 3);
    check("w0_core", 32'(rcore_id), 3);
    set_core(3, 1'b0, 1'b0, 11'h0, 8'h0, 2'd0);

    // Abort: core 0 len=3 read drops req after 2 beats, core 1 pending
    set_core(0, 1'b1, 1'b0, 11'h7FE, 8'h0, 2'd3);
    set_core(1, 1'b1, 1'b0, 11'h010, 8'h0, 2'd0);
    cyc();
    check("ab_gnt", 32'(gnt), 32'h1);
    check("ab_bid", 32'(burst_id), 10);
    cyc();
    check("ab_rv0", 32'(rvalid), 1);
    check("ab_d0", 32'(rdata), 1);
    cyc();
    check("ab_rv1", 32'(rvalid), 1);
    check("ab_d1", 32'(rdata), 2);
    check("ab_core", 32'(rcore_id), 0);
    req_v[0] = 1'b0;
    cyc();
    check("ab_rel", 32'(gnt), 0);
    check("ab_norv", 32'(rvalid), 0);
    cyc();
    check("ab_next_gnt", 32'(gnt), 32'h2);
    check("ab_next_bid", 32'(burst_id), 11);
    check("ab_still_norv", 32'(rvalid), 0);
    cyc();
    check("ab_next_rv", 32'(rvalid), 1);
    check("ab_next_data", 32'(rdata), 32'hA5);
    check("ab_next_core", 32'(rcore_id), 1);
    req_v = '0;
    cyc();
    check("end_gnt", 32'(gnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mp_mem_arbiter_n.md
Name: mp_mem_arbiter_n

Overview:
- Parametrised successor to the two-level multiprocessor memory DUT.
- Arbitrates NUM_CORES requesters onto one internal single-port memory of 2**AW words x DW bits.
- Supports locked incrementing bursts with address wrap.
- Returns read data tagged with the owning core index and a per-burst ID.
- Sits directly under the class-based testbench top, which drives one request channel per core.

Parameters:
- NUM_CORES, 4: number of requesting cores; must be at least 2.
- AW, 11: address width; memory depth is 2**AW.
- DW, 8: data width.
- BLW, 2: burst-length field width; maximum burst is 2**BLW beats.
- CIW, $clog2(NUM_CORES): core-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CORES  per-core request; held high for the whole burst.
- we  in  NUM_CORES  per-core write enable.
- addr  in  NUM_CORES*AW  per-core address, flattened; core i occupies bits [i*AW +: AW].
- wdata  in  NUM_CORES*DW  per-core write data, flattened.
- burst_len  in  NUM_CORES*BLW  per-core beat count minus 1.
- gnt  out  NUM_CORES  registered one-hot grant.
- rvalid  out  1  read data valid.
- rdata  out  DW  read data.
- rcore_id  out  CIW  core that owns rdata.
- burst_id  out  8  tag of the current or most recent burst.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: gnt=0, rvalid=0, rdata=0, rcore_id=0, burst_id=0, state IDLE, rr_ptr=0.
- Memory contents are not reset.
- Beat accepted: a beat is accepted in a cycle where req[i] && gnt[i].

State machine:
- IDLE:
  - If any req bit is high, choose winner w by round-robin: first requester at or after rr_ptr, searching upward with wrap.
  - At the edge: gnt <= one-hot(w), burst_id <= burst_id+1 (wraps 255->0), beat counter k <= 0, go to BURST.
  - If no req is high, stay in IDLE with gnt=0.
- BURST, first accepted beat (k=0):
  - Latch base=addr[w], dir=we[w], len=burst_len[w].
  - Perform access at address base.
- BURST, later beats:
  - Access address (base+k) mod 2**AW; wrap 2**AW-1 -> 0.
  - Core addr, we and burst_len are ignored after beat 0.
- Write beat: mem[address] <= wdata[w] at the edge ending the beat.
- Read beat: at that edge, rdata <= mem[address], rvalid <= 1, rcore_id <= w.
  - rvalid is 1 for exactly one cycle per read beat, 1 cycle latency.
  - A read beat following a write beat to the same address returns the new data.
- Final beat (k==len):
  - At the edge: gnt <= 0, rr_ptr <= (w+1) mod NUM_CORES, go to IDLE.
  - This leaves a mandatory one-cycle bubble, so minimum throughput is one burst per len+2 cycles.
- Abort: if req[w] drops while in BURST:
  - No access that cycle.
  - gnt <= 0, rr_ptr <= w+1, go to IDLE.
  - Already-issued rvalid still completes normally.
- Losing requesters stay pending with no timeout.
- Simultaneous events: requests arriving during BURST are not considered until IDLE.
- Reset mid-burst: all outputs return to reset values the next cycle. Memory writes already performed persist.

Optional Feature:
- Macro: MP_ARB_FIXED_PRIO_EN.
- Defined: IDLE picks the lowest-index requesting core, and rr_ptr is unused. Core 0 can starve the other cores.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Reset hold: rst=1 for 2 cycles with all req=1 -> gnt=0, rvalid=0, burst_id=0 throughout.
- Single write then read:
  - Core 2 writes 0xA5 to addr 0x010 with len=0 -> gnt[2] high for 1 cycle, burst_id=1.
  - Core 2 then reads 0x010 -> rvalid one cycle after the accepted beat, rdata=0xA5, rcore_id=2, burst_id=2.
- Round-robin fairness: cores 0,1,3 hold req continuously with len=0 -> grant order 0,1,3,0,1,3, each grant followed by a 1-cycle gap.
- Burst with wrap:
  - Core 1 writes len=3 at base 0x7FE with data 1,2,3,4 -> mem[0x7FE]=1, mem[0x7FF]=2, mem[0x000]=3, mem[0x001]=4.
  - 4-beat read from base 0x7FE returns 1,2,3,4 on consecutive rvalid cycles.
- Abort: core 0 starts a len=3 read and drops req after 2 beats -> exactly 2 rvalid pulses, gnt[0] low the next cycle, and a pending core 1 is granted next.
- MP_ARB_FIXED_PRIO_EN defined: cores 0 and 3 continuously requesting -> every grant goes to core 0.
